// File: rtl/serial_dac_pkg.sv
// Shared types and default parameter values for the serial DAC controller.
package serial_dac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam int DEF_DATA_W     = 12;
    localparam int DEF_NUM_CH     = 1;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_LD_LOW_CYC = 2;

endpackage

// File: rtl/sdac_bit_timer.sv
// Bit-phase counter: produces the serial clock level and an end-of-bit pulse
// for one serial bit lasting CLK_DIV cycles of clk_X4 (negedge domain).
module sdac_bit_timer
    import serial_dac_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_X4,
    input  logic rst_n,
    input  logic run,
    output logic clk_level,
    output logic bit_end
);

    localparam int PH_W = $clog2(CLK_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV / 2);

    logic [PH_W-1:0] phase;

    // Phase is held at zero whenever no bit is being emitted, so each frame starts aligned.
    always_ff @(negedge clk_X4 or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (!run || phase == PH_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    assign bit_end   = run && (phase == PH_LAST);
    assign clk_level = (phase >= PH_HALF);

endmodule

// File: rtl/serial_dac_ctrl.sv
// Serial DAC controller: shifts NUM_CH daisy-chained DAC words MSB first, then strobes LD_5.
// Optional feature: define SERIAL_DAC_REPEAT_EN for continuous refresh of the last frame.
module serial_dac_ctrl
    import serial_dac_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int LD_LOW_CYC = DEF_LD_LOW_CYC
) (
    input  logic                     clk_X4,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     din_valid,
    input  logic [NUM_CH*DATA_W-1:0] din_data,
    output logic                     din_ready,
    output logic                     busy,
    output logic                     CLK_3,
    output logic                     SDI_4,
    output logic                     LD_5
);

    localparam int TOTAL = NUM_CH * DATA_W;
    localparam int BIT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int LD_W  = (LD_LOW_CYC > 1) ? $clog2(LD_LOW_CYC) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL - 1);
    localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(LD_LOW_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [BIT_W-1:0] bit_cnt;
    logic [LD_W-1:0]  ld_cnt;
    logic [TOTAL-1:0] shreg;
    logic [TOTAL-1:0] rpt_frame;
    logic             accept;
    logic             restart;
    logic             shift_run;
    logic             bit_end;
    logic             bit_clk;
    logic             last_bit;
    logic             ld_last;

    assign accept    = din_valid && din_ready;
    assign shift_run = (state == ST_SHIFT) && enable;
    assign last_bit  = bit_end && (bit_cnt == BIT_LAST);
    assign ld_last   = (state == ST_LOAD) && (ld_cnt == LD_LAST);

    sdac_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk_X4    (clk_X4),
        .rst_n     (rst_n),
        .run       (shift_run),
        .clk_level (bit_clk),
        .bit_end   (bit_end)
    );

`ifdef SERIAL_DAC_REPEAT_EN
    logic             rpt_pend;
    logic [TOTAL-1:0] frame;

    // rpt_pend marks the single IDLE cycle that follows a completed LOAD.
    always_ff @(negedge clk_X4 or negedge rst_n) begin
        if (!rst_n) begin
            rpt_pend <= 1'b0;
            frame    <= '0;
        end else begin
            rpt_pend <= ld_last && enable;
            if (accept) begin
                frame <= din_data;
            end
        end
    end

    assign restart   = (state == ST_IDLE) && rpt_pend && enable && !din_valid;
    assign rpt_frame = frame;
`else
    assign restart   = 1'b0;
    assign rpt_frame = '0;
`endif

    // State register
    always_ff @(negedge clk_X4 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping enable abandons the frame without a load strobe.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept || restart) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (last_bit) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!enable || ld_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame shift register and bit/load counters
    always_ff @(negedge clk_X4 or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            ld_cnt  <= '0;
        end else begin
            if (accept) begin
                shreg <= din_data;
            end else if (restart) begin
                shreg <= rpt_frame;
            end else if (shift_run && bit_end) begin
                shreg <= shreg << 1;
            end

            if (shift_run && bit_end) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
            end else if (!shift_run) begin
                bit_cnt <= '0;
            end

            if ((state == ST_LOAD) && enable && !ld_last) begin
                ld_cnt <= ld_cnt + 1'b1;
            end else begin
                ld_cnt <= '0;
            end
        end
    end

    // Output logic; rst_n gates din_ready so nothing is offered while reset is held.
    always_comb begin
        din_ready = 1'b0;
        busy      = 1'b0;
        CLK_3     = 1'b1;
        SDI_4     = 1'b0;
        LD_5      = 1'b1;
        case (state)
            ST_IDLE: begin
                din_ready = enable && rst_n;
            end
            ST_SHIFT: begin
                busy  = 1'b1;
                CLK_3 = bit_clk;
                SDI_4 = shreg[TOTAL-1];
            end
            ST_LOAD: begin
                busy = 1'b1;
                LD_5 = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_dac_ctrl.sv
// Directed bench for serial_dac_ctrl: one default instance and one two-channel instance.
module tb_serial_dac_ctrl;

`ifdef SERIAL_DAC_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic        clk_X4 = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic        din_valid = 1'b0;
    logic [23:0] din_data = '0;
    logic        sel = 1'b0;

    logic en1, en2;
    logic rdy1, busy1, clk1, sdi1, ld1;
    logic rdy2, busy2, clk2, sdi2, ld2;

    int n_vec = 0;
    int n_err = 0;

    logic rdy_log  [0:127];
    logic busy_log [0:127];
    logic clk_log  [0:127];
    logic sdi_log  [0:127];
    logic ld_log   [0:127];

    always #5 clk_X4 = ~clk_X4;

    assign en1 = sel ? 1'b0 : enable;
    assign en2 = sel ? enable : 1'b0;

    serial_dac_ctrl u_dut (
        .clk_X4    (clk_X4),
        .rst_n     (rst_n),
        .enable    (en1),
        .din_valid (din_valid),
        .din_data  (din_data[11:0]),
        .din_ready (rdy1),
        .busy      (busy1),
        .CLK_3     (clk1),
        .SDI_4     (sdi1),
        .LD_5      (ld1)
    );

    serial_dac_ctrl #(
        .DATA_W (12),
        .NUM_CH (2)
    ) u_dut2 (
        .clk_X4    (clk_X4),
        .rst_n     (rst_n),
        .enable    (en2),
        .din_valid (din_valid),
        .din_data  (din_data),
        .din_ready (rdy2),
        .busy      (busy2),
        .CLK_3     (clk2),
        .SDI_4     (sdi2),
        .LD_5      (ld2)
    );

    function automatic logic [4:0] outs();
        return sel ? {rdy2, busy2, clk2, sdi2, ld2} : {rdy1, busy1, clk1, sdi1, ld1};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after posedge, away from the negedge.
    task automatic step();
        @(posedge clk_X4);
        #1;
    endtask

    // Log entry i holds cycle i+1 after acceptance; stimulus actions follow each sample.
    task automatic capture(input int n, input bit auto_drop, input int vld_off_at,
                           input int en_off_at, input int en_on_at,
                           input int vld_on_at, input logic [23:0] nd);
        logic [4:0] o;
        for (int i = 0; i < n; i++) begin
            o = outs();
            {rdy_log[i], busy_log[i], clk_log[i], sdi_log[i], ld_log[i]} = o;
            if (auto_drop && o[3]) din_valid = 1'b0;
            if (i == vld_off_at) din_valid = 1'b0;
            if (i == en_off_at) enable = 1'b0;
            if (i == en_on_at) enable = 1'b1;
            if (i == vld_on_at) begin
                din_valid = 1'b1;
                din_data  = nd;
            end
            step();
        end
    endtask

    task automatic send(input logic [23:0] d);
        din_valid = 1'b1;
        din_data  = d;
        step();
    endtask

    task automatic idle_gap(input bit new_sel);
        enable    = 1'b0;
        din_valid = 1'b0;
        step();
        sel = new_sel;
        step();
        check("gap_idle", 64'(outs()), 64'(5'b00101));
        enable = 1'b1;
        step();
    endtask

    function automatic logic [47:0] sdi_vec(input int c0);
        logic [47:0] v;
        for (int k = 0; k < 48; k++) v[47-k] = sdi_log[c0-1+k];
        return v;
    endfunction

    function automatic logic [47:0] clk_vec(input int c0);
        logic [47:0] v;
        for (int k = 0; k < 48; k++) v[47-k] = clk_log[c0-1+k];
        return v;
    endfunction

    function automatic int rises(input int n);
        int r = 0;
        for (int i = 1; i < n; i++) if (!clk_log[i-1] && clk_log[i]) r++;
        return r;
    endfunction

    function automatic int ld_lows(input int n);
        int r = 0;
        for (int i = 0; i < n; i++) if (!ld_log[i]) r++;
        return r;
    endfunction

    function automatic int first_ld_low(input int n);
        for (int i = 0; i < n; i++) if (!ld_log[i]) return i + 1;
        return 0;
    endfunction

    function automatic int busy_cnt(input int n);
        int r = 0;
        for (int i = 0; i < n; i++) if (busy_log[i]) r++;
        return r;
    endfunction

    function automatic int sdi_ones(input int c0, input int c1);
        int r = 0;
        for (int c = c0; c <= c1; c++) if (sdi_log[c-1]) r++;
        return r;
    endfunction

    initial begin
        // reset values, then first acceptance
        #2;
        check("reset_outs", 64'(outs()), 64'(5'b00101));
        step();
        rst_n  = 1'b1;
        enable = 1'b1;
        step();
        check("idle_ready", 64'(outs()), 64'(5'b10101));

        // one-shot 12'hAAA
        send(24'h000AAA);
        capture(52, 1'b1, -1, -1, -1, -1, '0);
        check("aaa_sdi", 64'(sdi_vec(1)), 64'h0000_F0F0F0F0F0F0);
        check("aaa_clk", 64'(clk_vec(1)), 64'h0000_333333333333);
        check("aaa_rises", 64'(rises(52)), 64'd12);
        check("aaa_ld_cnt", 64'(ld_lows(52)), 64'd2);
        check("aaa_ld_first", 64'(first_ld_low(52)), 64'd49);
        check("aaa_busy_cnt", 64'(busy_cnt(51)), 64'd50);
        check("aaa_busy_51", 64'(busy_log[50]), 64'd0);
        check("aaa_ready_shift", 64'(rdy_log[9]), 64'd0);
        check("aaa_busy_52", 64'(busy_log[51]), 64'(REPEAT));
        idle_gap(1'b0);

        // second value held valid during SHIFT
        send(24'h000123);
        capture(99, 1'b0, 51, -1, -1, 0, 24'h000456);
        check("hold_ready_c1", 64'(rdy_log[0]), 64'd0);
        check("hold_ready_ld", 64'(rdy_log[48]), 64'd0);
        check("hold_ready_c51", 64'(rdy_log[50]), 64'd1);
        check("hold_sdi_f1", 64'(sdi_vec(1)), 64'h0000_000F00F000FF);
        check("hold_sdi_f2", 64'(sdi_vec(52)), 64'h0000_0F000F0F0FF0);
        check("hold_ld_cnt", 64'(ld_lows(99)), 64'd2);
        idle_gap(1'b0);

        // enable dropped in bit 5, re-enabled with valid already high
        send(24'h000FFF);
        capture(80, 1'b1, -1, 21, 24, 22, 24'h000801);
        check("abort_sdi_pre", 64'(sdi_ones(1, 22)), 64'd22);
        check("abort_c23", 64'({rdy_log[22], busy_log[22], clk_log[22], sdi_log[22], ld_log[22]}), 64'(5'b00101));
        check("abort_ready_c25", 64'(rdy_log[24]), 64'd0);
        check("abort_busy_c26", 64'(busy_log[25]), 64'd1);
        check("abort_sdi_new", 64'(sdi_vec(26)), 64'h0000_F0000000000F);
        check("abort_ld_cnt", 64'(ld_lows(80)), 64'd2);
        check("abort_ld_first", 64'(first_ld_low(80)), 64'd74);
        idle_gap(1'b0);

        // asynchronous reset mid-SHIFT
        send(24'h000FFF);
        capture(10, 1'b1, -1, -1, -1, -1, '0);
        check("rst_pre", 64'(outs()), 64'(5'b01111));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 64'(outs()), 64'(5'b00101));
        rst_n = 1'b1;
        step();
        send(24'h000801);
        capture(60, 1'b1, -1, -1, -1, -1, '0);
        check("rst_resume_sdi", 64'(sdi_vec(1)), 64'h0000_F0000000000F);
        check("rst_resume_clk", 64'(clk_vec(1)), 64'h0000_333333333333);
        idle_gap(1'b0);

        // continuous refresh (or wait in IDLE when disabled)
        send(24'h0005A5);
        capture(104, 1'b1, -1, -1, -1, -1, '0);
        check("rpt_sdi_f1", 64'(sdi_vec(1)), 64'h0000_0F0FF0F00F0F);
        check("rpt_gap", 64'({rdy_log[50], busy_log[50]}), 64'(2'b10));
        check("rpt_sdi_f2", 64'(sdi_vec(52)), REPEAT ? 64'h0000_0F0FF0F00F0F : 64'h0);
        check("rpt_ld_cnt", 64'(ld_lows(104)), REPEAT ? 64'd4 : 64'd2);
        idle_gap(1'b1);

        // two daisy-chained channels, 24'hFFF000
        send(24'hFFF000);
        capture(99, 1'b1, -1, -1, -1, -1, '0);
        check("ch2_ones_hi", 64'(sdi_ones(1, 48)), 64'd48);
        check("ch2_ones_lo", 64'(sdi_ones(49, 96)), 64'd0);
        check("ch2_rises", 64'(rises(99)), 64'd24);
        check("ch2_ld_cnt", 64'(ld_lows(99)), 64'd2);
        check("ch2_ld_first", 64'(first_ld_low(99)), 64'd97);
        check("ch2_busy_cnt", 64'(busy_cnt(99)), 64'd98);
        idle_gap(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
